// File: rtl/edge_pkg.sv
// edge_pkg
// Shared definitions for the edge-detection front end: the row cache state
// machine encoding, frame geometry helpers and the default location of the
// output region in word memory.
//   row_width()   : 32-bit words per frame row (4 pixels per word)
//   frame_words() : words in a whole frame
//   slot_next()   : step a line-bank slot index 0 -> 1 -> 2 -> 0
package edge_pkg;

    // Output pixel word 0 sits directly after a 352x288 input frame.
    localparam int OUT_BASE_DEFAULT = 25344;

    typedef enum logic [1:0] {
        IDLE,
        PREFILL,
        STREAM,
        DONE
    } state_t;

    function automatic int row_width(input int width);
        return width / 4;
    endfunction

    function automatic int frame_words(input int width, input int height);
        return (width / 4) * height;
    endfunction

    function automatic logic [1:0] slot_next(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

endpackage

// File: rtl/row_cache_if.sv
// row_cache_if
// Bundles the accelerator-facing request/response signals and the
// single-port word memory bus of the row cache.
//   start, en, we, dataW          : accelerator requests
//   dataRa, dataRb, dataRc         : rows r-1, r, r+1 at the requested column
//   row_cached                     : cache primed, streaming allowed
//   mem_en, mem_we, mem_addr,
//   mem_dataW, mem_dataR           : word memory port (read data one cycle late)
// The slave modport is the row cache; the master modport is its environment
// (accelerator plus memory).
interface row_cache_if #(
    parameter int ADDR_W = 16
) ();

    logic              start;
    logic              en;
    logic              we;
    logic [31:0]       dataW;
    logic [31:0]       dataRa;
    logic [31:0]       dataRb;
    logic [31:0]       dataRc;
    logic              row_cached;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_dataW;
    logic [31:0]       mem_dataR;

    modport slave (
        input  start, en, we, dataW, mem_dataR,
        output dataRa, dataRb, dataRc, row_cached,
        output mem_en, mem_we, mem_addr, mem_dataW
    );

    modport master (
        output start, en, we, dataW, mem_dataR,
        input  dataRa, dataRb, dataRc, row_cached,
        input  mem_en, mem_we, mem_addr, mem_dataW
    );

endinterface

// File: rtl/line_buffer_bank.sv
// line_buffer_bank
// One row of the line cache: DEPTH x 32 simple dual-port RAM.
//   clk, rst : clock and synchronous active-high reset (clears read data only)
//   rd_en    : capture mem[rd_addr] into rd_data at the clock edge
//   rd_addr  : read column
//   rd_data  : registered read data, holds while rd_en is low
//   wr_en    : write wr_data to mem[wr_addr] at the clock edge
//   wr_addr  : write column
//   wr_data  : write data
// A read and a write to the same column in one cycle return the old word.
module line_buffer_bank #(
    parameter int DEPTH = 88,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/row_cache.sv
// row_cache
// Memory-side companion of the edge-detection accelerator. Primes a
// three-row line cache from the input frame, then serves each accelerator
// read with the same column of rows r-1, r and r+1 while prefetching row r+2
// into the bank that row r-1 vacates. Accelerator writes are forwarded to the
// output region starting at OUT_BASE.
//   clk, rst : clock and synchronous active-high reset
//   bus      : row_cache_if slave (accelerator requests, dataR*, row_cached,
//              word memory port)
module row_cache
    import edge_pkg::*;
#(
    parameter int WIDTH    = 352,
    parameter int HEIGHT   = 288,
    parameter int ADDR_W   = 16,
    parameter int OUT_BASE = OUT_BASE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    row_cache_if.slave bus
);

    localparam int RW = row_width(WIDTH);
    localparam int FW = frame_words(WIDTH, HEIGHT);
    localparam int CW = (RW > 1) ? $clog2(RW) : 1;
    localparam int RB = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [ADDR_W-1:0] ROW_WORDS  = ADDR_W'(RW);
    localparam logic [ADDR_W-1:0] FILL_WORDS = ADDR_W'(2 * RW);
    localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FW);
    localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(FW - 1);
    localparam logic [ADDR_W-1:0] OUT_ORIGIN = ADDR_W'(OUT_BASE);
    localparam logic [CW-1:0]     LAST_COL   = CW'(RW - 1);
    localparam logic [RB-1:0]     LAST_ROW   = RB'(HEIGHT - 1);

    state_t            state;
    // Next input word to fetch. During STREAM it equals (r+2)*ROW_WIDTH + c,
    // so reaching FRAME_END is the same as r+2 >= HEIGHT.
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] wr_cnt;
    logic [RB-1:0]     row;
    logic [CW-1:0]     col;
    logic [1:0]        slot_b;
    logic              cached_q;

    // A memory read issued this cycle lands in a bank next cycle.
    logic              pend_valid;
    logic [1:0]        pend_slot;
    logic [CW-1:0]     pend_col;

    // Bank selectors for dataR*, frozen at the last read request with the
    // top/bottom row replication already resolved.
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic [1:0]        sel_c;

    logic              rd_req;
    logic              wr_req;
    logic              fill_issue;
    logic              prefetch;
    logic [1:0]        slot_a;
    logic [1:0]        slot_c;
    logic [1:0]        fill_slot;
    logic [CW-1:0]     fill_col;
    logic [31:0]       bank_q [3];

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] w0,
                                         input logic [31:0] w1, input logic [31:0] w2);
        case (s)
            2'd1:    return w1;
            2'd2:    return w2;
            default: return w0;
        endcase
    endfunction

    always_comb begin
        rd_req     = (state == STREAM) && bus.en && !bus.we;
        wr_req     = (state == STREAM) && bus.en && bus.we;
        fill_issue = (state == PREFILL) && (fetch_addr < FILL_WORDS);
        prefetch   = rd_req && (fetch_addr < FRAME_END);
        slot_c     = slot_next(slot_b);
        slot_a     = slot_next(slot_c);
        // Prefill addresses 0..2*ROW_WIDTH-1 map to rows 0 and 1 in banks 0 and 1.
        if (fetch_addr >= ROW_WORDS) begin
            fill_slot = 2'd1;
            fill_col  = CW'(fetch_addr - ROW_WORDS);
        end else begin
            fill_slot = 2'd0;
            fill_col  = CW'(fetch_addr);
        end
    end

    // Prefill/prefetch reads and accelerator writes never share a cycle:
    // writes are only accepted in STREAM and prefetches only on reads.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_dataW = '0;
        if (fill_issue || prefetch) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = fetch_addr;
        end else if (wr_req) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = OUT_ORIGIN + wr_cnt;
            bus.mem_dataW = bus.dataW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fetch_addr <= '0;
            wr_cnt     <= '0;
            row        <= '0;
            col        <= '0;
            slot_b     <= 2'd0;
            cached_q   <= 1'b0;
            pend_valid <= 1'b0;
            pend_slot  <= 2'd0;
            pend_col   <= '0;
            sel_a      <= 2'd0;
            sel_b      <= 2'd0;
            sel_c      <= 2'd0;
        end else begin
            pend_valid <= fill_issue || prefetch;
            if (fill_issue) begin
                pend_slot <= fill_slot;
                pend_col  <= fill_col;
            end else if (prefetch) begin
                pend_slot <= slot_a;
                pend_col  <= col;
            end
            if (fill_issue || prefetch) begin
                fetch_addr <= fetch_addr + 1'b1;
            end

            case (state)
                IDLE: begin
                    cached_q   <= 1'b0;
                    fetch_addr <= '0;
                    wr_cnt     <= '0;
                    row        <= '0;
                    col        <= '0;
                    slot_b     <= 2'd0;
                    if (bus.start) begin
                        state <= PREFILL;
                    end
                end

                // The last prefill word is written to its bank on the same
                // edge that moves us to STREAM.
                PREFILL: begin
                    if (fetch_addr == FILL_WORDS) begin
                        state    <= STREAM;
                        cached_q <= 1'b1;
                    end
                end

                STREAM: begin
                    if (rd_req) begin
                        sel_b <= slot_b;
                        sel_a <= (row == '0) ? slot_b : slot_a;
                        sel_c <= (row == LAST_ROW) ? slot_b : slot_c;
                        if (col == LAST_COL) begin
                            col <= '0;
                            // Past the last row the cursor stays put so later
                            // reads keep returning last-row words.
                            if (row != LAST_ROW) begin
                                row    <= row + 1'b1;
                                slot_b <= slot_c;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                    if (wr_req) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == LAST_WORD) begin
                            state    <= DONE;
                            cached_q <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    cached_q <= 1'b0;
                    if (!bus.start) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_bank
        line_buffer_bank #(
            .DEPTH (RW),
            .AW    (CW)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .rd_en   (rd_req),
            .rd_addr (col),
            .rd_data (bank_q[k]),
            .wr_en   (pend_valid && (pend_slot == 2'(k))),
            .wr_addr (pend_col),
            .wr_data (bus.mem_dataR)
        );
    end

    assign bus.dataRa     = pick(sel_a, bank_q[0], bank_q[1], bank_q[2]);
    assign bus.dataRb     = pick(sel_b, bank_q[0], bank_q[1], bank_q[2]);
    assign bus.dataRc     = pick(sel_c, bank_q[0], bank_q[1], bank_q[2]);
    assign bus.row_cached = cached_q;

endmodule

// File: tb/tb_row_cache.sv
// tb_row_cache
// Directed bench for row_cache on a 16x4 frame (4 words per row, 16 words),
// output region at word 16. The memory answers a read of address k with k one
// cycle later and records words written to the output region.
module tb_row_cache;
    import edge_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    row_cache_if #(.ADDR_W(16)) bus ();

    row_cache #(
        .WIDTH    (16),
        .HEIGHT   (4),
        .ADDR_W   (16),
        .OUT_BASE (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected results of the read at cursor index i = 4*r + c.
    int exp_a  [16] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    int exp_b  [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    int exp_c  [16] = '{4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 12, 13, 14, 15};
    int exp_pf [16] = '{8, 9, 10, 11, 12, 13, 14, 15, -1, -1, -1, -1, -1, -1, -1, -1};

    logic [31:0] out_mem [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            bus.mem_dataR <= '0;
        end else if (bus.mem_en && !bus.mem_we) begin
            bus.mem_dataR <= 32'(bus.mem_addr);
        end
        if (bus.mem_en && bus.mem_we && bus.mem_addr >= 16'd16 && bus.mem_addr < 16'd32) begin
            out_mem[bus.mem_addr[3:0]] <= bus.mem_dataW;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.en    = 1'b0;
        bus.we    = 1'b0;
        bus.dataW = '0;
        repeat (2) @(negedge clk);
        checks++; if (bus.dataRa !== 32'd0) begin errors++; $display("[TB] FAIL reset_dataRa: got %h expected 0", bus.dataRa); end
        checks++; if (bus.dataRb !== 32'd0) begin errors++; $display("[TB] FAIL reset_dataRb: got %h expected 0", bus.dataRb); end
        checks++; if (bus.dataRc !== 32'd0) begin errors++; $display("[TB] FAIL reset_dataRc: got %h expected 0", bus.dataRc); end
        checks++; if (bus.row_cached !== 1'b0) begin errors++; $display("[TB] FAIL reset_row_cached: got %b expected 0", bus.row_cached); end
        checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_en_we: got %b%b expected 00", bus.mem_en, bus.mem_we); end
        checks++; if (bus.mem_addr !== 16'd0 || bus.mem_dataW !== 32'd0) begin errors++; $display("[TB] FAIL reset_mem_bus: got addr %0d data %h expected 0/0", bus.mem_addr, bus.mem_dataW); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state, IDLE); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.mem_en !== 1'b0 || dut.state !== IDLE) begin errors++; $display("[TB] FAIL idle_hold: got mem_en %b state %0d expected 0/IDLE", bus.mem_en, dut.state); end
    endtask

    task automatic test_prefill();
        @(negedge clk);
        bus.start = 1'b1;
        #1;
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("[TB] FAIL prefill_before_T1: got mem_en %b expected 0", bus.mem_en); end
        // Accelerator requests (reads and writes) must be ignored while priming.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.en    = 1'b1;
            bus.we    = 1'(k % 2);
            bus.dataW = 32'h5555_0000 + 32'(k);
            #1;
            checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("[TB] FAIL prefill_en k=%0d: got %b expected 1", k, bus.mem_en); end
            checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL prefill_we k=%0d: got %b expected 0", k, bus.mem_we); end
            checks++; if (bus.mem_addr !== 16'(k)) begin errors++; $display("[TB] FAIL prefill_addr k=%0d: got %0d expected %0d", k, bus.mem_addr, k); end
            checks++; if (bus.row_cached !== 1'b0) begin errors++; $display("[TB] FAIL prefill_cached k=%0d: got %b expected 0", k, bus.row_cached); end
        end
        @(negedge clk);
        bus.en = 1'b0;
        bus.we = 1'b0;
        #1;
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("[TB] FAIL prefill_T9_en: got %b expected 0", bus.mem_en); end
        checks++; if (bus.row_cached !== 1'b0) begin errors++; $display("[TB] FAIL prefill_T9_cached: got %b expected 0", bus.row_cached); end
        @(negedge clk);
        #1;
        checks++; if (bus.row_cached !== 1'b1) begin errors++; $display("[TB] FAIL prefill_T10_cached: got %b expected 1", bus.row_cached); end
        checks++; if (dut.state !== STREAM) begin errors++; $display("[TB] FAIL prefill_T10_state: got %0d expected %0d", dut.state, STREAM); end
        checks++; if (bus.dataRa !== 32'd0 || bus.dataRb !== 32'd0 || bus.dataRc !== 32'd0) begin
            errors++; $display("[TB] FAIL prefill_dataR_hold: got %h %h %h expected 0 0 0", bus.dataRa, bus.dataRb, bus.dataRc);
        end
    endtask

    task automatic test_read_write_pairs();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.en = 1'b1;
            bus.we = 1'b0;
            #1;
            if (exp_pf[i] >= 0) begin
                checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'(exp_pf[i])) begin
                    errors++; $display("[TB] FAIL pair_prefetch i=%0d: got en %b we %b addr %0d expected 1 0 %0d", i, bus.mem_en, bus.mem_we, bus.mem_addr, exp_pf[i]);
                end
            end else begin
                checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("[TB] FAIL pair_no_prefetch i=%0d: got en %b expected 0", i, bus.mem_en); end
            end
            @(negedge clk);
            bus.en    = 1'b1;
            bus.we    = 1'b1;
            bus.dataW = (i == 0) ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(i);
            #1;
            checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'(16 + i)) begin
                errors++; $display("[TB] FAIL pair_write_addr i=%0d: got en %b we %b addr %0d expected 1 1 %0d", i, bus.mem_en, bus.mem_we, bus.mem_addr, 16 + i);
            end
            checks++; if (bus.mem_dataW !== bus.dataW) begin errors++; $display("[TB] FAIL pair_write_data i=%0d: got %h expected %h", i, bus.mem_dataW, bus.dataW); end
            checks++; if (bus.dataRa !== 32'(exp_a[i])) begin errors++; $display("[TB] FAIL pair_dataRa i=%0d: got %0d expected %0d", i, bus.dataRa, exp_a[i]); end
            checks++; if (bus.dataRb !== 32'(exp_b[i])) begin errors++; $display("[TB] FAIL pair_dataRb i=%0d: got %0d expected %0d", i, bus.dataRb, exp_b[i]); end
            checks++; if (bus.dataRc !== 32'(exp_c[i])) begin errors++; $display("[TB] FAIL pair_dataRc i=%0d: got %0d expected %0d", i, bus.dataRc, exp_c[i]); end
            if (i == 5) begin
                @(negedge clk);
                bus.en = 1'b0;
                bus.we = 1'b0;
                #1;
                checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("[TB] FAIL gap_mem_en: got %b expected 0", bus.mem_en); end
                checks++; if (bus.dataRa !== 32'd1 || bus.dataRb !== 32'd5 || bus.dataRc !== 32'd9) begin
                    errors++; $display("[TB] FAIL gap_dataR_hold: got %0d %0d %0d expected 1 5 9", bus.dataRa, bus.dataRb, bus.dataRc);
                end
            end
        end
        @(negedge clk);
        bus.en = 1'b0;
        bus.we = 1'b0;
        #1;
        checks++; if (bus.row_cached !== 1'b0) begin errors++; $display("[TB] FAIL done_cached: got %b expected 0", bus.row_cached); end
        checks++; if (dut.state !== DONE) begin errors++; $display("[TB] FAIL done_state: got %0d expected %0d", dut.state, DONE); end
    endtask

    task automatic test_done_idle();
        @(negedge clk);
        bus.en = 1'b1;
        bus.we = 1'b0;
        #1;
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("[TB] FAIL done_ignore_req: got mem_en %b expected 0", bus.mem_en); end
        @(negedge clk);
        checks++; if (dut.state !== DONE || bus.dataRb !== 32'd15) begin
            errors++; $display("[TB] FAIL done_hold: got state %0d dataRb %0d expected %0d 15", dut.state, bus.dataRb, DONE);
        end
        bus.start = 1'b0;
        bus.en    = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (dut.state !== IDLE || bus.row_cached !== 1'b0) begin
            errors++; $display("[TB] FAIL done_to_idle: got state %0d cached %b expected %0d 0", dut.state, bus.row_cached, IDLE);
        end
        checks++; if (out_mem[0] !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL out_word0: got %h expected deadbeef", out_mem[0]); end
        checks++; if (out_mem[15] !== 32'hC0DE_000F) begin errors++; $display("[TB] FAIL out_word15: got %h expected c0de000f", out_mem[15]); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'd0) begin
            errors++; $display("[TB] FAIL reprime_addr0: got en %b addr %0d expected 1 0", bus.mem_en, bus.mem_addr);
        end
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.row_cached === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL reprime_cached: got no row_cached within 20 cycles expected 1"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (bus.dataRa !== 32'(exp_a[i-1]) || bus.dataRb !== 32'(exp_b[i-1]) || bus.dataRc !== 32'(exp_c[i-1])) begin
                    errors++; $display("[TB] FAIL b2b_dataR i=%0d: got %0d %0d %0d expected %0d %0d %0d", i - 1,
                                       bus.dataRa, bus.dataRb, bus.dataRc, exp_a[i-1], exp_b[i-1], exp_c[i-1]);
                end
            end
            if (i < 9) begin
                bus.en = 1'b1;
                bus.we = 1'b0;
                #1;
                if (exp_pf[i] >= 0) begin
                    checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'(exp_pf[i])) begin
                        errors++; $display("[TB] FAIL b2b_prefetch i=%0d: got en %b addr %0d expected 1 %0d", i, bus.mem_en, bus.mem_addr, exp_pf[i]);
                    end
                end else begin
                    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_prefetch i=%0d: got en %b expected 0", i, bus.mem_en); end
                end
            end else begin
                bus.en = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.dataRa !== 32'd0 || bus.dataRb !== 32'd0 || bus.dataRc !== 32'd0) begin
            errors++; $display("[TB] FAIL midreset_dataR: got %h %h %h expected 0 0 0", bus.dataRa, bus.dataRb, bus.dataRc);
        end
        checks++; if (bus.row_cached !== 1'b0) begin errors++; $display("[TB] FAIL midreset_cached: got %b expected 0", bus.row_cached); end
        checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'd0 || bus.mem_dataW !== 32'd0) begin
            errors++; $display("[TB] FAIL midreset_mem: got en %b we %b addr %0d data %h expected all 0", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_dataW);
        end
        checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL midreset_state: got %0d expected %0d", dut.state, IDLE); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'd0) begin
            errors++; $display("[TB] FAIL restart_addr0: got en %b we %b addr %0d expected 1 0 0", bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        checks++; if (dut.state !== PREFILL) begin errors++; $display("[TB] FAIL restart_state: got %0d expected %0d", dut.state, PREFILL); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        $display("[TB] row_cache directed test starting");
        test_reset();
        test_prefill();
        test_read_write_pairs();
        test_done_idle();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/row_cache.md
Name: row_cache

Overview:
- Feeds the edge-detection accelerator. Reads the input frame from the single-port word memory and keeps a three-row line cache.
- On each accelerator read request it presents the same column word of rows r-1, r and r+1 on dataRa, dataRb and dataRc.
- Forwards accelerator writes to the output region of memory and raises row_cached once the first two rows are resident.
- It is the memory-side counterpart of the accelerator's en/we/dataR/dataW/row_cached interface.

Parameters:
- WIDTH, 352, frame width in pixels (4 pixels per 32-bit word).
- HEIGHT, 288, frame height in rows.
- ADDR_W, 16, memory address width.
- OUT_BASE, 25344, word address of output pixel word 0 (directly after the input frame).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  frame request level (shared with the accelerator).
- en  in  1  accelerator access request.
- we  in  1  accelerator write qualifier (1 = write, 0 = read).
- dataW  in  32  accelerator write data.
- dataRa  out  32  row r-1 word.
- dataRb  out  32  row r word.
- dataRc  out  32  row r+1 word.
- row_cached  out  1  cache primed, streaming allowed.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_dataW  out  32  memory write data.
- mem_dataR  in  32  memory read data, valid the cycle after a read.

Behaviour:
- Constants: ROW_WIDTH = WIDTH/4; FRAME_WORDS = ROW_WIDTH*HEIGHT.
- Reset (synchronous): state IDLE; all counters 0; dataRa/b/c = 0; row_cached = 0; mem_* = 0.
- State IDLE: mem_* = 0. Move to PREFILL when start = 1.
- State PREFILL: issue mem reads at addresses 0 .. 2*ROW_WIDTH-1, one per cycle.
  - Data returning at address k is written to bank (k / ROW_WIDTH), column (k mod ROW_WIDTH).
  - The cycle after the last data is written, enter STREAM with row_cached = 1.
  - This is 2*ROW_WIDTH+2 cycles after start was sampled in IDLE.
  - Accelerator requests in PREFILL are ignored: no memory traffic, dataR* hold.
- State STREAM: row_cached = 1. A read cursor (r, c) starts at (0, 0).
  - Bank slots rotate: slot_b = r mod 3, slot_c = (r+1) mod 3, slot_a = (r+2) mod 3 (equal to (r-1) mod 3).
  - Read request (en=1, we=0):
    - Registered next cycle: dataRb = bank[slot_b][c]; dataRa = bank[slot_a][c], or the dataRb value when r = 0; dataRc = bank[slot_c][c], or the dataRb value when r = HEIGHT-1.
    - Same cycle (combinational): if r+2 < HEIGHT, prefetch read with mem_en = 1, mem_addr = (r+2)*ROW_WIDTH + c. The returned word is written to bank[slot_a][c] the following cycle.
    - If r+2 >= HEIGHT, mem_en = 0.
    - Cursor advances: c+1, wrapping to 0 with r+1 after c = ROW_WIDTH-1. Slots rotate on the wrap.
  - Write request (en=1, we=1):
    - Combinational: mem_en = 1, mem_we = 1, mem_addr = OUT_BASE + wr_cnt, mem_dataW = dataW.
    - wr_cnt increments.
    - When the write with wr_cnt = FRAME_WORDS-1 completes, enter DONE.
  - en = 0: no memory access, dataR* hold.
- State DONE: row_cached = 0; mem_* = 0; requests ignored. Return to IDLE when start = 0.
- Read requests beyond FRAME_WORDS: return the last-row words again; no prefetch; the cursor does not wrap past HEIGHT-1.
- Hazards:
  - The read of bank[slot_a][c] happens at the request cycle. The prefetch overwrite lands one cycle later, so read-before-write is guaranteed.
  - A prefetch return may coincide with an accelerator write on the memory port. This is legal: the bank write and the memory write are independent.
- Memory-side outputs are combinational from state, counters, en and we. dataR* and row_cached are registered.
- start deasserted mid-frame is ignored. Only rst aborts. A reset mid-operation returns to IDLE with all outputs at their reset values next cycle.

Decomposition:
- Shared package (edge_pkg):
  - ROW_WIDTH and FRAME_WORDS derivation functions.
  - State enum IDLE/PREFILL/STREAM/DONE.
  - OUT_BASE default.
- Sub-module line_buffer_bank: ROW_WIDTH x 32 simple dual-port RAM, one synchronous read port and one write port, read-before-write. Instantiated three times.

Test Plan:
Common setup: WIDTH=16, HEIGHT=4, OUT_BASE=16, with a memory model where word k = k.
- Start asserted at cycle T → PREFILL reads on addresses 0..7 over cycles T+1..T+8; row_cached rises at T+10; mem_* = 0 before T+1.
- First read at (0,0) → next cycle dataRa=0, dataRb=0, dataRc=4; same cycle mem_en=1, mem_we=0, mem_addr=8.
- Read at (1,2) → dataRa=2, dataRb=6, dataRc=10; no prefetch is issued because r+2=3 is not < HEIGHT... correction: r+2=3 < 4, so mem_addr=14 is issued. Read at (3,1) → dataRa=9, dataRb=13, dataRc=13, mem_en=0.
- Write with dataW=0xDEADBEEF as the first write → mem_en=1, mem_we=1, mem_addr=16, mem_dataW=0xDEADBEEF; after 16 alternating read/write pairs → DONE, row_cached=0; start dropped → IDLE.
- Read request with en=0 gaps and requests issued during PREFILL → no memory access, dataR* unchanged, cursor unchanged.
- rst pulsed mid-STREAM at (2,1) → next cycle all outputs 0 and state IDLE; a new start re-primes from address 0.
